// File: rtl/fifo_drain_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_drain_reader
// Brief   : Drains a registered-read FIFO into a valid/ready stream through a
//           2-entry prefetch buffer, with a flush that drops buffered and
//           in-flight words.
// Revision: 1.0
// ============================================================================
module fifo_drain_reader #(
  parameter type T              = logic [31:0],
  parameter int  PREFETCH_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  output logic fifo_read_en,
  input  T     fifo_read_data,
  input  logic fifo_empty,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready,
  input  logic flush,
  output logic idle
);

  localparam logic [2:0] c_DEPTH = 3'(PREFETCH_DEPTH);

  logic [1:0] occ_q, occ_d;
  logic       inflight_q;
  logic       discard_q, discard_d;
  logic       head_q, head_d;
  T           mem_q [2];

  logic       w_pop;
  logic       w_capture;
  logic       w_wr_idx;
  logic [2:0] w_pending;
  logic [2:0] w_occ_sum;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[head_q];
  assign idle      = (occ_q == 2'd0) && !inflight_q && fifo_empty;

  always_comb begin
    w_pop     = out_valid && out_ready && !flush;
    w_capture = inflight_q && !discard_q;
    w_wr_idx  = head_q ^ occ_q[0];
    // Words committed after this cycle: buffered plus returning, minus the pop.
    w_pending = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, w_pop};
    w_occ_sum = {1'b0, occ_q} + {2'b0, w_capture} - {2'b0, w_pop};

    fifo_read_en = !reset && !flush && !fifo_empty && (w_pending < c_DEPTH);

    occ_d     = w_occ_sum[1:0];
    head_d    = w_pop ? ~head_q : head_q;
    discard_d = 1'b0;
    if (flush) begin
      occ_d     = 2'd0;
      head_d    = 1'b0;
      discard_d = inflight_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      head_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_read_en;
      discard_q  <= discard_d;
      head_q     <= head_d;
      if (!flush) begin
        assert (w_occ_sum <= c_DEPTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_capture) begin
      mem_q[w_wr_idx] <= fifo_read_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_drain_reader
// Brief   : Directed bench for fifo_drain_reader with a registered-read FIFO
//           model, an issue-rule vector table and multi-cycle sequences.
// Revision: 1.0
// ============================================================================
module tb_fifo_drain_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_read_en;
  logic [31:0] fifo_read_data;
  logic        fifo_empty;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        flush;
  logic        idle;

  fifo_drain_reader #(.T(logic [31:0]), .PREFETCH_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_read_en  (fifo_read_en),
    .fifo_read_data(fifo_read_data),
    .fifo_empty    (fifo_empty),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .flush         (flush),
    .idle          (idle)
  );

  always #10 clk = ~clk;

  // Upstream FIFO model: registered read, pointer-based.
  logic [31:0] fifo_mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        fifo_clr = 1'b0;
  logic        ovr_en = 1'b0;
  logic        ovr_val = 1'b0;
  int          bad_rd = 0;

  assign fifo_empty = ovr_en ? ovr_val : (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read_en) begin
      if (wr_ptr == rd_ptr) bad_rd <= bad_rd + 1;
      fifo_read_data <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  // Delivery monitor
  logic [31:0] got [256];
  int          got_cyc [256];
  int          got_n = 0;
  int          rd_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && out_valid && out_ready && !flush) begin
      got[got_n]     <= out_data;
      got_cyc[got_n] <= cyc;
      got_n          <= got_n + 1;
    end
    if (!reset && fifo_read_en) rd_cnt <= rd_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  typedef struct {
    logic phase;
    logic empty;
    logic ready;
    logic fl;
    logic exp_re;
    logic exp_valid;
    logic exp_idle;
  } vec_t;

  vec_t vecs [8];

  // Combinational checks with registered state frozen (no clock edge inside).
  task automatic apply_phase(input logic p);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].phase == p) begin
        ovr_en    = 1'b1;
        ovr_val   = vecs[i].empty;
        out_ready = vecs[i].ready;
        flush     = vecs[i].fl;
        #1;
        chk($sformatf("vec%0d_read_en", i), {31'd0, fifo_read_en}, {31'd0, vecs[i].exp_re});
        chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
        chk($sformatf("vec%0d_idle", i), {31'd0, idle}, {31'd0, vecs[i].exp_idle});
      end
    end
    ovr_en    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pulses;
    int rc0;
    int maxout;
    int outstanding;
    logic found;
    logic [31:0] exp5 [6];

    //                phase empty ready flush  re valid idle
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    reset     = 1'b1;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset held 3 cycles with the FIFO empty
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_read_en", {31'd0, fifo_read_en}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    apply_phase(1'b0);

    // Full-rate stream
    @(negedge clk);
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) push(v);
    for (int i = 0; i < 14; i++) begin
      #1;
      chk($sformatf("t2_read_en_c%0d", i), {31'd0, fifo_read_en}, (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("t2_out_valid_c%0d", i), {31'd0, out_valid},
          (i >= 2 && i < 10) ? 32'd1 : 32'd0);
      if (i >= 2 && i < 10) chk($sformatf("t2_out_data_c%0d", i), out_data, i - 2);
      @(negedge clk);
    end
    #1;
    chk("t2_idle_after", {31'd0, idle}, 32'd1);

    // Backpressure: only two prefetches while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    for (int v = 0; v < 8; v++) push(v);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fifo_read_en) pulses++;
      @(negedge clk);
    end
    #1;
    chk("t3_pulses", pulses, 32'd2);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out_data", out_data, 32'd0);
    apply_phase(1'b1);
    @(negedge clk);
    base = got_n;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (got_n - base) < 8; i++) @(negedge clk);
    chk("t3_count", got_n - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_word%0d", i), got[base + i], i);
      chk($sformatf("t3_gap%0d", i), got_cyc[base + i] - got_cyc[base], i);
    end

    // Toggling out_ready
    @(negedge clk);
    base = got_n;
    rc0 = rd_cnt;
    maxout = 0;
    for (int v = 0; v < 8; v++) push(v);
    for (int i = 0; i < 60 && (got_n - base) < 8; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk);
      outstanding = (rd_cnt - rc0) - (got_n - base);
      if (outstanding > maxout) maxout = outstanding;
    end
    chk("t4_count", got_n - base, 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_word%0d", i), got[base + i], i);
    chk("t4_max_outstanding_le2", {31'd0, (maxout <= 2)}, 32'd1);
    chk("t4_reads", rd_cnt - rc0, 32'd8);

    // Flush with word 3 buffered and word 4 in flight
    out_ready = 1'b1;
    @(negedge clk);
    base = got_n;
    for (int v = 0; v < 8; v++) push(v);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (out_valid && out_data == 32'd3) found = 1'b1;
      else @(negedge clk);
    end
    chk("t5_found_word3", {31'd0, found}, 32'd1);
    flush = 1'b1;
    #1;
    chk("t5_flush_read_en", {31'd0, fifo_read_en}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t5_out_valid_after", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 30 && (got_n - base) < 6; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_count", got_n - base, 32'd6);
    exp5 = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7};
    for (int i = 0; i < 6; i++) chk($sformatf("t5_word%0d", i), got[base + i], exp5[i]);
    chk("t5_idle", {31'd0, idle}, 32'd1);

    // Reset mid-stream after word 2 delivered, then refill
    @(negedge clk);
    base = got_n;
    for (int v = 0; v < 8; v++) push(v);
    for (int i = 0; i < 20 && (got_n - base) < 3; i++) @(negedge clk);
    reset = 1'b1;
    fifo_clr = 1'b1;
    #1;
    chk("t6_delivered_before_reset", got_n - base, 32'd3);
    @(negedge clk);
    fifo_clr = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_read_en", {31'd0, fifo_read_en}, 32'd0);
    chk("t6_idle", {31'd0, idle}, 32'd1);
    reset = 1'b0;
    push(32'd100);
    push(32'd101);
    for (int i = 0; i < 20 && (got_n - base) < 5; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_count", got_n - base, 32'd5);
    chk("t6_word100", got[base + 3], 32'd100);
    chk("t6_word101", got[base + 4], 32'd101);

    chk("read_while_empty", bad_rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
